// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, grouped so the
// cache and its environment share one bundle.
interface instruction_cache_if;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole
// 128-bit block refill from instruction memory on a miss.
//
// state | meaning
// IDLE  | lookups served; a miss latches the block address and starts a refill
// FETCH | MEM_READ held until memory drops MEM_BUSYWAIT, then the line is written
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input logic CLK,
  input logic RESET,
  instruction_cache_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index, fill_index;
  logic [TAG_W-1:0]      tag, fill_tag;
  logic                  hit, refill;
  logic                  mem_read_q, mem_read_d;
  logic [27:0]           mem_address_q, mem_address_d;
  logic                  unused_addr_bits;

  assign offset           = bus.ADDRESS[3:2];
  assign index            = bus.ADDRESS[3+INDEX_BITS:4];
  assign tag              = bus.ADDRESS[31:4+INDEX_BITS];
  assign unused_addr_bits = ^bus.ADDRESS[1:0];

  // The refill is steered by the latched block address, not the live PC.
  assign fill_index = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag   = mem_address_q[27:INDEX_BITS];

  assign hit             = valid_q[index] && (tag_q[index] == tag);
  assign bus.INSTRUCTION = data_q[index][{offset, 5'd0} +: 32];
  assign bus.BUSYWAIT    = (state_q != IDLE) || !hit;
  assign bus.MEM_READ    = mem_read_q;
  assign bus.MEM_ADDRESS = mem_address_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_address_q <= 28'h0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      if (refill) valid_q[fill_index] <= 1'b1;
    end
  end

  // Tags and data need no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (refill) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= bus.MEM_READDATA;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    refill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d       = FETCH;
          mem_read_d    = 1'b1;
          mem_address_d = bus.ADDRESS[31:4];
        end
      end
      FETCH: begin
        if (!bus.MEM_BUSYWAIT) begin
          refill     = 1'b1;
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: behavioural memory with
// programmable latency, tag/valid reference model and an expectation queue.
module tb_instruction_cache;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  instruction_cache_if bus();

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Backing memory: block 0 holds the known program words, elsewhere a pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0) begin
      case (a[3:2])
        2'd0: return 32'h11;
        2'd1: return 32'h22;
        2'd2: return 32'h33;
        default: return 32'h44;
      endcase
    end
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  int mem_latency = 0;
  int mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= bus.MEM_READ ? mem_cnt + 1 : 0;
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < mem_latency);
  assign bus.MEM_READDATA = {mem_word({bus.MEM_ADDRESS, 4'hC}), mem_word({bus.MEM_ADDRESS, 4'h8}),
                             mem_word({bus.MEM_ADDRESS, 4'h4}), mem_word({bus.MEM_ADDRESS, 4'h0})};

  // Reference tag/valid state
  logic        m_valid [8];
  logic [24:0] m_tag   [8];

  function automatic logic is_miss(input logic [31:0] a);
    return !(m_valid[a[6:4]] && m_tag[a[6:4]] == a[31:7]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    m_valid[a[6:4]] = 1'b1;
    m_tag[a[6:4]]   = a[31:7];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          busy;
    int          mr;
    logic [27:0] maddr;
  } exp_t;
  exp_t sb[$];

  task automatic push_expect(input logic [31:0] a, input int n);
    exp_t e;
    logic miss;
    miss    = is_miss(a);
    e.instr = mem_word(a);
    e.busy  = miss ? n + 2 : 0;
    e.mr    = miss ? n + 1 : 0;
    e.maddr = a[31:4];
    sb.push_back(e);
    if (miss) model_fill(a);
  endtask

  // Called in the cycle ADDRESS was driven; runs until the stall clears.
  task automatic measure(input logic [31:0] a);
    int busy = 0;
    int mr = 0;
    logic [27:0] maddr = '0;
    logic seen = 1'b0;
    logic moved = 1'b0;
    exp_t e;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) break;
      busy++;
      if (bus.MEM_READ) begin
        if (!seen) maddr = bus.MEM_ADDRESS;
        else if (bus.MEM_ADDRESS !== maddr) moved = 1'b1;
        seen = 1'b1;
        mr++;
      end
    end
    e = sb.pop_front();
    chk($sformatf("busy_cycles@%08h", a), 32'(busy), 32'(e.busy));
    chk($sformatf("mem_read_cycles@%08h", a), 32'(mr), 32'(e.mr));
    chk($sformatf("mem_read_idle@%08h", a), 32'(bus.MEM_READ), 32'h0);
    if (e.mr != 0) begin
      chk($sformatf("mem_address@%08h", a), 32'(maddr), 32'(e.maddr));
      chk($sformatf("mem_address_stable@%08h", a), 32'(moved), 32'h0);
    end
    chk($sformatf("instruction@%08h", a), bus.INSTRUCTION, e.instr);
  endtask

  task automatic fetch(input logic [31:0] a, input int n);
    @(posedge CLK);
    #1;
    mem_latency = n;
    push_expect(a, n);
    bus.ADDRESS = a;
    measure(a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bursts;
    logic prev_mr, bad1, bad2;
    exp_t e;

    model_clear();
    bus.ADDRESS = 32'hFFFF_FFFC;
    repeat (3) @(negedge CLK);
    chk("reset_busywait", 32'(bus.BUSYWAIT), 32'h1);
    chk("reset_mem_read", 32'(bus.MEM_READ), 32'h0);
    chk("reset_mem_address", 32'(bus.MEM_ADDRESS), 32'h0);

    // Release reset with the fetch start address already on the bus
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    mem_latency = 2;
    push_expect(32'hFFFF_FFFC, 2);
    measure(32'hFFFF_FFFC);

    fetch(32'h0000_0000, 5);
    fetch(32'h0000_0004, 0);
    fetch(32'h0000_0008, 0);
    fetch(32'h0000_000C, 0);

    // Conflict on index 0
    fetch(32'h0000_0080, 2);
    fetch(32'h0000_0000, 1);

    // PC moves from 0x10 to 0x40 while the 0x10 refill is in flight
    @(posedge CLK);
    #1;
    mem_latency = 3;
    model_fill(32'h10);
    push_expect(32'h40, 3);
    bus.ADDRESS = 32'h10;
    bursts = 0;
    prev_mr = 1'b0;
    bad1 = 1'b0;
    bad2 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ && !prev_mr) bursts++;
      if (bus.MEM_READ && bursts == 1 && bus.MEM_ADDRESS !== 28'h1) bad1 = 1'b1;
      if (bus.MEM_READ && bursts == 2 && bus.MEM_ADDRESS !== 28'h4) bad2 = 1'b1;
      prev_mr = bus.MEM_READ;
      if (!bus.BUSYWAIT && c > 2) break;
      if (c == 2) begin
        @(posedge CLK);
        #1;
        bus.ADDRESS = 32'h40;
      end
    end
    e = sb.pop_front();
    chk("redirect_bursts", 32'(bursts), 32'd2);
    chk("redirect_first_block", 32'(bad1), 32'h0);
    chk("redirect_second_block", 32'(bad2), 32'h0);
    chk("redirect_instruction", bus.INSTRUCTION, e.instr);
    fetch(32'h0000_0010, 0);
    fetch(32'h0000_0040, 0);

    // Reset asserted in the third FETCH cycle of a miss on 0x20
    @(posedge CLK);
    #1;
    mem_latency = 6;
    bus.ADDRESS = 32'h20;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("abort_mem_read", 32'(bus.MEM_READ), 32'h0);
    chk("abort_busywait", 32'(bus.BUSYWAIT), 32'h1);
    chk("abort_mem_address", 32'(bus.MEM_ADDRESS), 32'h0);
    model_clear();
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    mem_latency = 1;
    push_expect(32'h20, 1);
    measure(32'h20);

    // Mixed traffic over two tags per index, latencies 0..3
    for (int i = 0; i < 24; i++) begin
      fetch(32'($urandom_range(0, 63)) << 2, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
